// File: rtl/radix4_mul_arbiter_pkg.sv
// Shared constants for the two-requester sequenced radix-4 multiplier.
package radix4_mul_arbiter_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One radix-4 digit is retired per RUN cycle.
    function automatic int unsigned steps_of(input int unsigned width);
        return width / 2;
    endfunction

endpackage

// File: rtl/radix4_mul_arbiter_if.sv
// Request/acknowledge and result bus between the execution units and the shared multiplier.
interface radix4_mul_arbiter_if #(
    parameter int unsigned WIDTH = radix4_mul_arbiter_pkg::DEF_WIDTH
);
    logic               iReq0;
    logic [WIDTH-1:0]   iA0;
    logic [WIDTH-1:0]   iB0;
    logic               oAck0;
    logic               iReq1;
    logic [WIDTH-1:0]   iA1;
    logic [WIDTH-1:0]   iB1;
    logic               oAck1;
    logic [2*WIDTH-1:0] oResult;
    logic               oValid;
    logic               oOwner;
    logic               oBusy;

    modport master (
        output iReq0, iA0, iB0, iReq1, iA1, iB1,
        input  oAck0, oAck1, oResult, oValid, oOwner, oBusy
    );

    modport slave (
        input  iReq0, iA0, iB0, iReq1, iA1, iB1,
        output oAck0, oAck1, oResult, oValid, oOwner, oBusy
    );
endinterface

// File: rtl/radix4_digit_pp.sv
// Radix-4 partial product select: 0, A, 2A or 3A for one 2-bit multiplier digit.
module radix4_digit_pp #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_sh,
    input  logic [1:0]   digit,
    output logic [W-1:0] pp
);
    always_comb begin
        pp = '0;
        case (digit)
            2'd0:    pp = '0;
            2'd1:    pp = a_sh;
            2'd2:    pp = a_sh << 1;
            default: pp = (a_sh << 1) + a_sh;
        endcase
    end
endmodule

// File: rtl/radix4_mul_arbiter.sv
// Round-robin shared radix-4 shift-and-add multiplier; one digit per cycle,
// registered product returned with the owning requester index.
module radix4_mul_arbiter
    import radix4_mul_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    radix4_mul_arbiter_if.slave  bus
);
    localparam int unsigned STEPS = steps_of(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_served;
    logic             ack0_q;
    logic             ack1_q;
    logic             valid_q;
    logic             busy_q;
    logic             res_owner_q;
    logic [PW-1:0]    result_q;
    logic             grant_any;
    logic             grant_sel;
    logic             last_step;

    radix4_digit_pp #(.W(PW)) u_pp (
        .a_sh  (a_sh),
        .digit (b_sh[1:0]),
        .pp    (pp)
    );

    // Ties go to whoever was not served last.
    always_comb begin
        grant_any = bus.iReq0 | bus.iReq1;
        grant_sel = bus.iReq1 & (~bus.iReq0 | (last_served == REQ0));
        acc_sum   = acc + pp;
        last_step = (cnt == CNT_W'(STEPS - 1));
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_any) state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output registers; the product is loaded on the last RUN
    // edge so it is already visible while oValid is high in DONE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
            owner       <= REQ0;
            last_served <= REQ1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            res_owner_q <= REQ0;
            result_q    <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        a_sh        <= PW'(grant_sel ? bus.iA1 : bus.iA0);
                        b_sh        <= grant_sel ? bus.iB1 : bus.iB0;
                        acc         <= '0;
                        cnt         <= '0;
                        owner       <= grant_sel;
                        last_served <= grant_sel;
                        ack0_q      <= ~grant_sel;
                        ack1_q      <= grant_sel;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_sum;
                    a_sh <= a_sh << 2;
                    b_sh <= b_sh >> 2;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_step) begin
                        result_q    <= acc_sum;
                        res_owner_q <= owner;
                        valid_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oAck0   = ack0_q;
    assign bus.oAck1   = ack1_q;
    assign bus.oValid  = valid_q;
    assign bus.oBusy   = busy_q;
    assign bus.oOwner  = res_owner_q;
    assign bus.oResult = result_q;

endmodule

// File: tb/tb_radix4_mul_arbiter.sv
// Scoreboard bench for radix4_mul_arbiter: directed requests push expected
// products; a negedge monitor pops and compares on every oValid.
module tb_radix4_mul_arbiter;
    import radix4_mul_arbiter_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic        owner;
        logic [31:0] prod;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   prev_cyc = 0;
    bit   tie_mode = 1'b0;
    bit   have_prev = 1'b0;

    radix4_mul_arbiter_if #(.WIDTH(W)) bus ();

    radix4_mul_arbiter #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: scoreboard pop on oValid, ack exclusivity, tie spacing.
    always @(negedge Clock) begin
        exp_t e;
        if (bus.oAck0 || bus.oAck1)
            check("ack_exclusive", 32'(bus.oAck0 & bus.oAck1), 32'd0);
        if (bus.oValid) begin
            if (q.size() == 0) begin
                fail_now("unexpected_valid");
            end else begin
                e = q.pop_front();
                check("result", bus.oResult, e.prod);
                check("owner", 32'(bus.oOwner), 32'(e.owner));
                check("busy_in_done", 32'(bus.oBusy), 32'd1);
                if (tie_mode) begin
                    if (have_prev) check("valid_spacing", 32'(cyc - prev_cyc), 32'd10);
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
            end
        end
    end

    // Raise a request, hold it until acknowledged, then drop it and scramble operands.
    task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b,
                         input bit expect_res, input logic [31:0] prod, output int lat);
        bit got;
        if (expect_res) q.push_back('{owner: who, prod: prod});
        if (who == 1'b0) begin
            bus.iReq0 = 1'b1; bus.iA0 = a; bus.iB0 = b;
        end else begin
            bus.iReq1 = 1'b1; bus.iA1 = a; bus.iB1 = b;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge Clock);
            lat++;
            got = (who == 1'b0) ? bus.oAck0 : bus.oAck1;
        end
        if (who == 1'b0) begin
            bus.iReq0 = 1'b0; bus.iA0 = 16'hDEAD; bus.iB0 = 16'hBEEF;
        end else begin
            bus.iReq1 = 1'b0; bus.iA1 = 16'hDEAD; bus.iB1 = 16'hBEEF;
        end
        if (!got) fail_now("ack_timeout");
    endtask

    task automatic valid_latency(input string name, input int exp_n);
        int n = 0;
        while (!bus.oValid && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [2:0] order;
        int k;
        int n;

        Reset = 1'b1;
        bus.iReq0 = 1'b0; bus.iA0 = '0; bus.iB0 = '0;
        bus.iReq1 = 1'b0; bus.iA1 = '0; bus.iB1 = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        check("rst_result", bus.oResult, 32'd0);
        check("rst_valid", 32'(bus.oValid), 32'd0);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_owner", 32'(bus.oOwner), 32'd0);
        check("rst_acks", 32'({bus.oAck1, bus.oAck0}), 32'd0);

        // Single request with latency and hold checks.
        issue(1'b0, 16'd3, 16'd5, 1'b1, 32'd15, lat);
        check("single_ack_latency", 32'(lat), 32'd1);
        valid_latency("single_valid_latency", 8);
        repeat (3) @(negedge Clock);
        check("single_hold", bus.oResult, 32'd15);
        drain();

        issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, lat);
        drain();
        issue(1'b0, 16'h0000, 16'h1234, 1'b1, 32'h0000_0000, lat);
        drain();
        issue(1'b1, 16'h1234, 16'hE4E4, 1'b1, 32'h1046_8650, lat);
        drain();

        // Tie straight after reset: grants 0,1,0.
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        tie_mode  = 1'b1;
        have_prev = 1'b0;
        q.push_back('{owner: 1'b0, prod: 32'd30});
        q.push_back('{owner: 1'b1, prod: 32'h0003_0000});
        q.push_back('{owner: 1'b0, prod: 32'd30});
        bus.iA0 = 16'd5;     bus.iB0 = 16'd6;     bus.iReq0 = 1'b1;
        bus.iA1 = 16'h0100;  bus.iB1 = 16'h0300;  bus.iReq1 = 1'b1;
        order = 3'b010;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge Clock);
            n++;
            if (bus.oAck0 || bus.oAck1) begin
                check("tie_grant_order", 32'(bus.oAck1), 32'(order[k]));
                k++;
            end
        end
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        if (k < 3) fail_now("tie_grant_timeout");
        drain();
        tie_mode = 1'b0;

        // Request 1 arrives while request 0 is in RUN.
        issue(1'b0, 16'd7, 16'd9, 1'b1, 32'd63, lat);
        repeat (3) @(negedge Clock);
        issue(1'b1, 16'd2, 16'd2, 1'b1, 32'd4, lat);
        check("midop_ack1_latency", 32'(lat), 32'd7);
        drain();

        // Reset at RUN cycle 4 aborts with no oValid.
        issue(1'b0, 16'd9, 16'd9, 1'b0, 32'd0, lat);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("abort_busy", 32'(bus.oBusy), 32'd0);
        check("abort_result", bus.oResult, 32'd0);
        check("abort_valid", 32'(bus.oValid), 32'd0);
        repeat (12) @(negedge Clock);
        issue(1'b0, 16'd6, 16'd7, 1'b1, 32'd42, lat);
        check("post_abort_ack_latency", 32'(lat), 32'd1);
        valid_latency("post_abort_valid_latency", 8);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
